vend_multi_top: RTL and testbench
=================================

# vend_multi_top

Parametrised multi-product vending controller, the next generation of the single-item soda controller/datapath pair. It accumulates coin credit, accepts a product selection, and dispenses from one of N_ITEMS channels with per-channel stock tracking. It returns change, supports cancel/refund, and reports sold-out status. It sits between the coin acceptor/selection front end and the dispenser actuators and OLED status logic.

## Interface
- WIDTH, 8, width of coin values, prices, credit and change.
- N_ITEMS, 4, number of product channels (2..16).
- STOCK_W, 4, width of each channel's stock counter.
- INIT_STOCK, 8, per-channel stock loaded at reset (must be ≤ 2^STOCK_W−1).
- DISP_CYCLES, 16, length of the dispense pulse in clocks (≥1).
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- coin_valid  in  1  one-cycle pulse: a coin is presented.
- coin_val  in  WIDTH  value of the presented coin; valid with coin_valid.
- sel_valid  in  1  one-cycle pulse: a product is selected.
- sel_idx  in  IW=$clog2(N_ITEMS)  selected channel; valid with sel_valid.
- prices  in  N_ITEMS*WIDTH  flat price table; channel k occupies bits [k*WIDTH +: WIDTH].
- cancel  in  1  one-cycle pulse: refund the current credit.
- restock  in  1  one-cycle pulse: refill channel restock_idx.
- restock_idx  in  IW  channel to refill.
- credit  out  WIDTH  current accumulated credit.
- dispense  out  1  dispense actuator enable.
- disp_idx  out  IW  channel being dispensed; held stable while dispense is high.
- change_valid  out  1  one-cycle pulse: return change_amt.
- change_amt  out  WIDTH  change or refund value; valid with change_valid.
- coin_reject  out  1  one-cycle pulse: the coin presented last cycle was not accepted.
- sel_err  out  1  one-cycle pulse: the selection last cycle was refused.
- sold_out  out  N_ITEMS  bit k is high when stock[k] == 0.
- busy  out  1  high in DISPENSE and CHANGE.

## Operation
- States: IDLE (credit == 0), COLLECT (credit > 0), DISPENSE, CHANGE.
- **Coin acceptance (IDLE/COLLECT).** An accepted coin adds coin_val to credit, and the FSM moves IDLE→COLLECT.
  - If credit + coin_val would exceed 2^WIDTH−1 (computed at WIDTH+1 bits), the coin is rejected and credit is unchanged.
  - A coin_val of 0 is accepted with no effect.
- **Selection (IDLE/COLLECT).**
  - Refused with sel_err if sel_idx ≥ N_ITEMS, stock[sel_idx] == 0, or credit < price[sel_idx].
  - Otherwise the FSM latches disp_idx and change = credit − price, decrements stock[sel_idx], and enters DISPENSE.
- **DISPENSE.** dispense is held high for exactly DISP_CYCLES cycles, then the FSM enters CHANGE.
- **CHANGE.** Lasts one cycle. change_valid pulses with the latched change only if the change is nonzero. credit is cleared and the FSM enters IDLE.
- **Cancel (COLLECT).**
  - change_valid pulses with change_amt = credit, credit is cleared, and the FSM enters IDLE.
  - Cancel in IDLE is ignored (no pulse).
- **Outside IDLE/COLLECT.** In DISPENSE or CHANGE, coin_valid is rejected, and sel_valid and cancel are ignored (no sel_err).
- **Restock.** Sets stock[restock_idx] = 2^STOCK_W−1. It is honoured only in IDLE; in any other state, or with an out-of-range index, it is ignored.
- **Simultaneous events in one cycle (IDLE/COLLECT).**
  - cancel beats sel_valid; sel_valid is dropped silently.
  - With cancel and coin_valid together, the coin is rejected and the refund excludes it.
  - With sel_valid and coin_valid together, the selection is evaluated against the pre-coin credit.
    - If the selection is accepted, the coin is rejected.
    - If the selection is refused, the coin is accepted and sel_err pulses.

## Timing
- All outputs are registered.
- Reset values: state IDLE; credit 0; dispense 0; disp_idx 0; change_valid 0; change_amt 0; coin_reject 0; sel_err 0; busy 0; every stock = INIT_STOCK; sold_out = 0 if INIT_STOCK > 0.
- Asserting rst mid-operation aborts immediately. Credit is lost (no change pulse), dispense drops the next cycle, and stock is reloaded.
- Latencies:
  - coin_valid at edge t: credit updated at t+1; coin_reject visible at t+1.
  - Accepted sel_valid at t: dispense high from t+1 through t+DISP_CYCLES, busy high over the same window; sold_out updates at t+1.
  - CHANGE occupies cycle t+DISP_CYCLES+1, with change_valid in that cycle. IDLE resumes at t+DISP_CYCLES+2.
  - Cancel at t: change_valid at t+1, credit 0 at t+1.
- change_amt holds its last value when change_valid is low.

## Test plan
- **Exact payment, no change.** WIDTH=8, prices={50,75,100,125}; coins 25,25; select idx0 → credit 50; dispense high 16 cycles with disp_idx=0; no change_valid; stock[0] 8→7.
- **Overpay.** Coins 100,50; select idx1 (75) → dispense on idx1; change_valid with change_amt=75; credit 0 afterward.
- **Refusals.** Credit 25, select idx3 → sel_err, credit stays 25. Then cancel → change_valid with 25, FSM in IDLE.
- **Overflow and busy rejection.** Credit 200, coin 100 → coin_reject, credit stays 200. A coin during DISPENSE → coin_reject.
- **Sold out and restock.** Vend idx2 eight times → sold_out[2]=1 and a ninth selection gets sel_err. Restock idx2 in IDLE → stock 15, sold_out[2]=0.
- **Simultaneity and reset.** sel_valid(idx0, price 50) with coin 25 at credit 50 → vend, coin_reject. rst asserted mid-DISPENSE → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/vend_multi_top.sv
// Multi-product vending controller: coin credit, per-channel stock, timed dispense,
// change return and cancel/refund. All outputs are registered.
module vend_multi_top #(
    parameter int WIDTH       = 8,
    parameter int N_ITEMS     = 4,
    parameter int STOCK_W     = 4,
    parameter int INIT_STOCK  = 8,
    parameter int DISP_CYCLES = 16,
    localparam int IW         = $clog2(N_ITEMS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     coin_valid,
    input  logic [WIDTH-1:0]         coin_val,
    input  logic                     sel_valid,
    input  logic [IW-1:0]            sel_idx,
    input  logic [N_ITEMS*WIDTH-1:0] prices,
    input  logic                     cancel,
    input  logic                     restock,
    input  logic [IW-1:0]            restock_idx,
    output logic [WIDTH-1:0]         credit,
    output logic                     dispense,
    output logic [IW-1:0]            disp_idx,
    output logic                     change_valid,
    output logic [WIDTH-1:0]         change_amt,
    output logic                     coin_reject,
    output logic                     sel_err,
    output logic [N_ITEMS-1:0]       sold_out,
    output logic                     busy
);

    localparam int CW = $clog2(DISP_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DISPENSE,
        S_CHANGE
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     credit_q, credit_d;
    logic                 dispense_q, dispense_d;
    logic [IW-1:0]        disp_idx_q, disp_idx_d;
    logic                 change_valid_q, change_valid_d;
    logic [WIDTH-1:0]     change_amt_q, change_amt_d;
    logic                 coin_reject_q, coin_reject_d;
    logic                 sel_err_q, sel_err_d;
    logic [N_ITEMS-1:0]   sold_out_q, sold_out_d;
    logic                 busy_q, busy_d;
    logic [WIDTH-1:0]     pend_q, pend_d;
    logic [CW-1:0]        disp_cnt_q, disp_cnt_d;
    logic [STOCK_W-1:0]   stock_q [N_ITEMS];
    logic [STOCK_W-1:0]   stock_d [N_ITEMS];

    logic [WIDTH-1:0]     price_arr [N_ITEMS];
    logic                 in_window;
    logic                 sel_in_range;
    logic [IW-1:0]        sel_safe;
    logic [WIDTH:0]       coin_sum;
    logic                 do_refund;
    logic                 sel_ok;
    logic                 sel_bad;
    logic                 coin_ok;
    logic                 disp_done;

    for (genvar g = 0; g < N_ITEMS; g++) begin : g_price
        assign price_arr[g] = prices[g*WIDTH +: WIDTH];
    end

    // ------------------------------------------------------------------
    // State register and datapath flops
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            dispense_q     <= 1'b0;
            disp_idx_q     <= '0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
            coin_reject_q  <= 1'b0;
            sel_err_q      <= 1'b0;
            sold_out_q     <= (INIT_STOCK == 0) ? '1 : '0;
            busy_q         <= 1'b0;
            pend_q         <= '0;
            disp_cnt_q     <= '0;
            // NOTE: the stock table is a handful of flops, not a RAM, so it
            // can and must be reloaded on reset.
            for (int k = 0; k < N_ITEMS; k++) begin
                stock_q[k] <= STOCK_W'(INIT_STOCK);
            end
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            dispense_q     <= dispense_d;
            disp_idx_q     <= disp_idx_d;
            change_valid_q <= change_valid_d;
            change_amt_q   <= change_amt_d;
            coin_reject_q  <= coin_reject_d;
            sel_err_q      <= sel_err_d;
            sold_out_q     <= sold_out_d;
            busy_q         <= busy_d;
            pend_q         <= pend_d;
            disp_cnt_q     <= disp_cnt_d;
            stock_q        <= stock_d;
        end
    end

    // ------------------------------------------------------------------
    // Event decode and next-state logic
    // ------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of an always_comb so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        in_window    = (state_q == S_IDLE) || (state_q == S_COLLECT);
        sel_in_range = int'(sel_idx) < N_ITEMS;
        sel_safe     = sel_in_range ? sel_idx : '0;
        coin_sum     = {1'b0, credit_q} + {1'b0, coin_val};
        do_refund    = in_window && cancel && (state_q == S_COLLECT);
        // Selection is judged on pre-coin credit; cancel suppresses it silently.
        sel_ok       = in_window && !cancel && sel_valid && sel_in_range
                       && (stock_q[sel_safe] != '0)
                       && (credit_q >= price_arr[sel_safe]);
        sel_bad      = in_window && !cancel && sel_valid && !sel_ok;
        coin_ok      = in_window && coin_valid && !cancel && !sel_ok && !coin_sum[WIDTH];
        disp_done    = (state_q == S_DISPENSE) && (disp_cnt_q == '0);

        state_d = state_q;
        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (do_refund) begin
                    state_d = S_IDLE;
                end else if (sel_ok) begin
                    state_d = S_DISPENSE;
                end else if (coin_ok && (coin_sum[WIDTH-1:0] != '0)) begin
                    state_d = S_COLLECT;
                end
            end
            S_DISPENSE: begin
                if (disp_done) begin
                    state_d = S_CHANGE;
                end
            end
            S_CHANGE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output and datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        credit_d       = credit_q;
        disp_idx_d     = disp_idx_q;
        change_valid_d = 1'b0;
        change_amt_d   = change_amt_q;
        coin_reject_d  = coin_valid && !coin_ok;
        sel_err_d      = sel_bad;
        pend_d         = pend_q;
        disp_cnt_d     = disp_cnt_q;
        stock_d        = stock_q;

        if (do_refund) begin
            change_valid_d = 1'b1;
            change_amt_d   = credit_q;
            credit_d       = '0;
        end else if (sel_ok) begin
            disp_idx_d        = sel_idx;
            pend_d            = credit_q - price_arr[sel_safe];
            stock_d[sel_safe] = stock_q[sel_safe] - STOCK_W'(1);
            disp_cnt_d        = CW'(DISP_CYCLES - 1);
        end else if (coin_ok) begin
            credit_d = coin_sum[WIDTH-1:0];
        end

        case (state_q)
            S_DISPENSE: begin
                if (disp_done) begin
                    change_valid_d = (pend_q != '0);
                    if (pend_q != '0) begin
                        change_amt_d = pend_q;
                    end
                end else begin
                    disp_cnt_d = disp_cnt_q - CW'(1);
                end
            end
            S_CHANGE: begin
                credit_d = '0;
            end
            default: begin
            end
        endcase

        // Restock is applied last so it wins over a same-cycle decrement.
        if (restock && (state_q == S_IDLE) && (int'(restock_idx) < N_ITEMS)) begin
            stock_d[restock_idx] = '1;
        end

        dispense_d = (state_d == S_DISPENSE);
        busy_d     = (state_d == S_DISPENSE) || (state_d == S_CHANGE);
        for (int k = 0; k < N_ITEMS; k++) begin
            sold_out_d[k] = (stock_d[k] == '0);
        end
    end

    assign credit       = credit_q;
    assign dispense     = dispense_q;
    assign disp_idx     = disp_idx_q;
    assign change_valid = change_valid_q;
    assign change_amt   = change_amt_q;
    assign coin_reject  = coin_reject_q;
    assign sel_err      = sel_err_q;
    assign sold_out     = sold_out_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_vend_multi_top.sv
// Directed self-checking bench for vend_multi_top: payment, change, refusals,
// overflow, sold-out/restock, simultaneous events and mid-dispense reset.
module tb_vend_multi_top;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int DISP  = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             coin_valid = 1'b0;
    logic [WIDTH-1:0] coin_val = '0;
    logic             sel_valid = 1'b0;
    logic [1:0]       sel_idx = '0;
    logic [N*WIDTH-1:0] prices;
    logic             cancel = 1'b0;
    logic             restock = 1'b0;
    logic [1:0]       restock_idx = '0;
    logic [WIDTH-1:0] credit;
    logic             dispense;
    logic [1:0]       disp_idx;
    logic             change_valid;
    logic [WIDTH-1:0] change_amt;
    logic             coin_reject;
    logic             sel_err;
    logic [N-1:0]     sold_out;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    vend_multi_top #(
        .WIDTH(WIDTH), .N_ITEMS(N), .STOCK_W(4), .INIT_STOCK(8), .DISP_CYCLES(DISP)
    ) dut (
        .clk(clk), .rst(rst),
        .coin_valid(coin_valid), .coin_val(coin_val),
        .sel_valid(sel_valid), .sel_idx(sel_idx),
        .prices(prices), .cancel(cancel),
        .restock(restock), .restock_idx(restock_idx),
        .credit(credit), .dispense(dispense), .disp_idx(disp_idx),
        .change_valid(change_valid), .change_amt(change_amt),
        .coin_reject(coin_reject), .sel_err(sel_err),
        .sold_out(sold_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input int v);
        coin_valid = 1'b1;
        coin_val   = WIDTH'(v);
        tick();
        coin_valid = 1'b0;
    endtask

    // Select idx and watch the whole dispense/change sequence.
    task automatic vend(input int idx, input int exp_chg, input int exp_so);
        int n_disp, n_cv, cv_at, amt, idx_ok;
        sel_valid = 1'b1;
        sel_idx   = 2'(idx);
        tick();
        sel_valid = 1'b0;
        check("sold_out_upd", int'(sold_out[idx]), exp_so);
        check("busy_on", int'(busy), 1);
        n_disp = 0; n_cv = 0; cv_at = -1; amt = 0; idx_ok = 1;
        for (int i = 0; i < DISP + 2; i++) begin
            if (dispense) begin
                n_disp++;
                if (int'(disp_idx) != idx) idx_ok = 0;
            end
            if (change_valid) begin
                n_cv++;
                cv_at = i;
                amt   = int'(change_amt);
            end
            tick();
        end
        check("disp_len", n_disp, DISP);
        check("disp_idx", idx_ok, 1);
        check("chg_count", n_cv, (exp_chg != 0) ? 1 : 0);
        if (exp_chg != 0) begin
            check("chg_at", cv_at, DISP);
            check("chg_amt", amt, exp_chg);
        end
        check("idle_credit", int'(credit), 0);
        check("idle_busy", int'(busy), 0);
    endtask

    // Bounded wait for the FSM to leave DISPENSE/CHANGE, recording change pulses.
    task automatic wait_idle(output int n_cv, output int amt);
        int guard;
        n_cv = 0; amt = 0; guard = 0;
        while (busy && guard < 40) begin
            if (change_valid) begin
                n_cv++;
                amt = int'(change_amt);
            end
            tick();
            guard++;
        end
        check("idle_timeout", int'(busy), 0);
    endtask

    initial begin
        int n_cv, amt;
        prices = {8'd125, 8'd100, 8'd75, 8'd50};

        // Reset state
        tick(); tick();
        rst = 1'b0;
        check("rst_credit", int'(credit), 0);
        check("rst_dispense", int'(dispense), 0);
        check("rst_change_valid", int'(change_valid), 0);
        check("rst_change_amt", int'(change_amt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sold_out", int'(sold_out), 0);
        check("rst_coin_reject", int'(coin_reject), 0);
        check("rst_sel_err", int'(sel_err), 0);

        // Exact payment, no change
        coin(25);
        check("credit_25", int'(credit), 25);
        check("coin_ok", int'(coin_reject), 0);
        coin(25);
        check("credit_50", int'(credit), 50);
        vend(0, 0, 0);

        // Overpay: 150 for price 75
        coin(100);
        coin(50);
        check("credit_150", int'(credit), 150);
        vend(1, 75, 0);

        // Refused selection then cancel
        coin(25);
        sel_valid = 1'b1; sel_idx = 2'd3;
        tick();
        sel_valid = 1'b0;
        check("sel_err_low_credit", int'(sel_err), 1);
        check("credit_kept", int'(credit), 25);
        check("no_dispense", int'(dispense), 0);
        tick();
        check("sel_err_pulse", int'(sel_err), 0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("refund_valid", int'(change_valid), 1);
        check("refund_amt", int'(change_amt), 25);
        check("refund_credit", int'(credit), 0);
        tick();
        check("refund_pulse", int'(change_valid), 0);
        check("change_amt_hold", int'(change_amt), 25);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_idle_ignored", int'(change_valid), 0);

        // Overflow rejection and coin during DISPENSE
        coin(100);
        coin(100);
        coin(100);
        check("overflow_reject", int'(coin_reject), 1);
        check("overflow_credit", int'(credit), 200);
        sel_valid = 1'b1; sel_idx = 2'd3;
        tick();
        sel_valid = 1'b0;
        coin(10);
        check("busy_coin_reject", int'(coin_reject), 1);
        check("busy_dispense", int'(dispense), 1);
        wait_idle(n_cv, amt);
        check("idx3_chg_count", n_cv, 1);
        check("idx3_chg_amt", amt, 75);
        tick();
        check("idx3_credit", int'(credit), 0);

        // Sold out on channel 2 (price 100, stock 8)
        for (int k = 0; k < 8; k++) begin
            coin(100);
            vend(2, 0, (k == 7) ? 1 : 0);
        end
        coin(100);
        sel_valid = 1'b1; sel_idx = 2'd2;
        tick();
        sel_valid = 1'b0;
        check("soldout_sel_err", int'(sel_err), 1);
        check("soldout_no_disp", int'(dispense), 0);
        restock = 1'b1; restock_idx = 2'd2;
        tick();
        restock = 1'b0;
        check("restock_collect_ignored", int'(sold_out[2]), 1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("soldout_refund", int'(change_amt), 100);
        restock = 1'b1; restock_idx = 2'd2;
        tick();
        restock = 1'b0;
        check("restock_clears", int'(sold_out[2]), 0);
        // Restocked to 15: fourteen vends leave it available, the fifteenth empties it
        for (int k = 0; k < 15; k++) begin
            coin(100);
            vend(2, 0, (k == 14) ? 1 : 0);
        end

        // Accepted selection with simultaneous coin: coin rejected
        coin(50);
        sel_valid = 1'b1; sel_idx = 2'd0;
        coin_valid = 1'b1; coin_val = 8'd25;
        tick();
        sel_valid = 1'b0; coin_valid = 1'b0;
        check("simul_dispense", int'(dispense), 1);
        check("simul_coin_reject", int'(coin_reject), 1);
        check("simul_sel_err", int'(sel_err), 0);
        wait_idle(n_cv, amt);
        check("simul_no_change", n_cv, 0);

        // Refused selection with simultaneous coin: coin accepted, sel_err
        coin(25);
        sel_valid = 1'b1; sel_idx = 2'd1;
        coin_valid = 1'b1; coin_val = 8'd25;
        tick();
        sel_valid = 1'b0; coin_valid = 1'b0;
        check("refuse_sel_err", int'(sel_err), 1);
        check("refuse_coin_ok", int'(coin_reject), 0);
        check("refuse_credit", int'(credit), 50);
        // Cancel with coin: coin rejected, refund excludes it
        cancel = 1'b1;
        coin_valid = 1'b1; coin_val = 8'd25;
        tick();
        cancel = 1'b0; coin_valid = 1'b0;
        check("cancel_coin_reject", int'(coin_reject), 1);
        check("cancel_coin_amt", int'(change_amt), 50);

        // Reset in the middle of DISPENSE
        coin(50);
        sel_valid = 1'b1; sel_idx = 2'd0;
        tick();
        sel_valid = 1'b0;
        tick(); tick(); tick();
        check("pre_rst_dispense", int'(dispense), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_dispense", int'(dispense), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_credit", int'(credit), 0);
        check("mid_rst_change_valid", int'(change_valid), 0);
        check("mid_rst_change_amt", int'(change_amt), 0);
        check("mid_rst_disp_idx", int'(disp_idx), 0);
        check("mid_rst_sold_out", int'(sold_out), 0);
        tick();
        check("post_rst_change_valid", int'(change_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
